// File: rtl/text_buf_ctrl.sv
// Single-port 80x25 character RAM arbiter: display fetch > clear sequencer > host port.
// Optional blinking cursor inversion is enabled by defining TEXT_BUF_CURSOR_EN.
module text_buf_ctrl #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 25,
    parameter logic [7:0]  CLEAR_CHAR   = 8'h20,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] disp_pos,
    output logic [7:0]  disp_char,
    input  logic        h_valid,
    output logic        h_ready,
    input  logic        h_we,
    input  logic [10:0] h_addr,
    input  logic [7:0]  h_wdata,
    output logic [7:0]  h_rdata,
    output logic        h_rvalid,
    input  logic        clr_req,
    output logic        busy,
    input  logic        frame_tick,
    input  logic [10:0] cursor_pos
);

    localparam int          CELLS   = COLS * ROWS;
    localparam logic [10:0] CELLS_A = 11'(CELLS);
    localparam logic [10:0] LAST_A  = 11'(CELLS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [10:0] clr_addr_q, clr_addr_d;
    logic [10:0] last_pos_q, last_pos_d;
    logic [7:0]  disp_char_q, disp_char_d;
    logic [7:0]  h_rdata_q, h_rdata_d;
    logic        h_rvalid_q, h_rvalid_d;

    logic [7:0]  mem [0:CELLS-1];
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic        pos_change, disp_in, fetch, clr_start, h_ready_c, h_acc, h_in;
    logic [7:0]  cursor_mask;

    // An out-of-range display position still refreshes disp_char (to blank)
    // but does not claim the RAM, so only in-range changes block others.
    always_comb begin
        pos_change = (disp_pos != last_pos_q);
        disp_in    = (disp_pos < CELLS_A);
        fetch      = pos_change && disp_in;
        clr_start  = (state_q == IDLE) && clr_req;
        h_ready_c  = (state_q != CLEAR) && !fetch && !clr_start;
        h_acc      = h_valid && h_ready_c;
        h_in       = (h_addr < CELLS_A);
        last_pos_d = disp_pos;
    end

    always_comb begin
        ram_addr   = h_addr;
        ram_we     = 1'b0;
        ram_wdata  = h_wdata;
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (fetch) begin
            ram_addr = disp_pos;
        end else if (state_q == CLEAR) begin
            ram_addr  = clr_addr_q;
            ram_we    = 1'b1;
            ram_wdata = CLEAR_CHAR;
            if (clr_addr_q == LAST_A) begin
                state_d = IDLE;
            end else begin
                clr_addr_d = clr_addr_q + 11'd1;
            end
        end else if (h_acc && h_we && h_in) begin
            ram_we = 1'b1;
        end
        if (clr_start) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end
    end

    assign ram_rdata = mem[ram_addr];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

`ifdef TEXT_BUF_CURSOR_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = !blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign cursor_mask = (blink_q && (disp_pos == cursor_pos)) ? 8'h80 : 8'h00;
`else
    logic unused_cursor;
    assign unused_cursor = ^{frame_tick, cursor_pos, BLINK_FRAMES != 0};
    assign cursor_mask   = 8'h00;
`endif

    // Fetch and host read never share a cycle, so both read the same port.
    always_comb begin
        disp_char_d = disp_char_q;
        if (pos_change) begin
            disp_char_d = disp_in ? (ram_rdata ^ cursor_mask) : 8'h00;
        end
        h_rvalid_d = h_acc && !h_we;
        h_rdata_d  = h_rdata_q;
        if (h_rvalid_d) begin
            h_rdata_d = h_in ? ram_rdata : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            last_pos_q  <= 11'h7FF;
            disp_char_q <= 8'h00;
            h_rdata_q   <= 8'h00;
            h_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            last_pos_q  <= last_pos_d;
            disp_char_q <= disp_char_d;
            h_rdata_q   <= h_rdata_d;
            h_rvalid_q  <= h_rvalid_d;
        end
    end

    assign disp_char = disp_char_q;
    assign h_rdata   = h_rdata_q;
    assign h_rvalid  = h_rvalid_q;
    assign h_ready   = h_ready_c;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Directed bench for text_buf_ctrl; inputs change just after negedge, outputs sampled #1 later or at the next negedge.
module tb_text_buf_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] disp_pos;
    logic [7:0]  disp_char;
    logic        h_valid;
    logic        h_ready;
    logic        h_we;
    logic [10:0] h_addr;
    logic [7:0]  h_wdata;
    logic [7:0]  h_rdata;
    logic        h_rvalid;
    logic        clr_req;
    logic        busy;
    logic        frame_tick;
    logic [10:0] cursor_pos;

    int checks = 0;
    int passes = 0;

    text_buf_ctrl #(.BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_pos   (disp_pos),
        .disp_char  (disp_char),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .h_rdata    (h_rdata),
        .h_rvalid   (h_rvalid),
        .clr_req    (clr_req),
        .busy       (busy),
        .frame_tick (frame_tick),
        .cursor_pos (cursor_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic host_write(input logic [10:0] a, input logic [7:0] d);
        int n = 0;
        h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
        #1;
        while (!h_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        h_valid = 1'b0; h_we = 1'b0;
        if (n >= 50) begin
            checks++;
            $display("FAIL host_write_timeout addr=%0d h_ready stayed 0, required 1", a);
        end
    endtask

    task automatic host_read(input logic [10:0] a, output logic [7:0] d, output logic v);
        int n = 0;
        h_valid = 1'b1; h_we = 1'b0; h_addr = a;
        #1;
        while (!h_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        h_valid = 1'b0;
        d = h_rdata;
        v = h_rvalid;
        if (n >= 50) begin
            checks++;
            $display("FAIL host_read_timeout addr=%0d h_ready stayed 0, required 1", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; disp_pos = 11'd2047; h_valid = 1'b0; h_we = 1'b0;
        h_addr = '0; h_wdata = '0; clr_req = 1'b0; frame_tick = 1'b0; cursor_pos = 11'd3;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (disp_char !== 8'h00) $display("FAIL reset_disp_char got=%h exp=00", disp_char); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++;
        if (h_rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", h_rvalid); else passes++;
        checks++;
        if (h_rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", h_rdata); else passes++;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", h_ready); else passes++;
    endtask

    task automatic test_host_rw();
        h_valid = 1'b1; h_we = 1'b1; h_addr = 11'd5; h_wdata = 8'h41;
        #1;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL write_ready got=%b exp=1", h_ready); else passes++;
        @(negedge clk);
        h_we = 1'b0;
        #1;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL read_ready got=%b exp=1", h_ready); else passes++;
        @(negedge clk);
        h_valid = 1'b0;
        checks++;
        if (h_rvalid !== 1'b1) $display("FAIL read_rvalid got=%b exp=1", h_rvalid); else passes++;
        checks++;
        if (h_rdata !== 8'h41) $display("FAIL read_rdata got=%h exp=41", h_rdata); else passes++;
        @(negedge clk);
        checks++;
        if (h_rvalid !== 1'b0) $display("FAIL rvalid_pulse got=%b exp=0", h_rvalid); else passes++;
    endtask

    task automatic test_fetch();
        host_write(11'd0, 8'h11);
        host_write(11'd1, 8'h42);
        disp_pos = 11'd0;
        #1;
        checks++;
        if (h_ready !== 1'b0) $display("FAIL fetch0_ready got=%b exp=0", h_ready); else passes++;
        @(negedge clk);
        checks++;
        if (disp_char !== 8'h11) $display("FAIL fetch0_char got=%h exp=11", disp_char); else passes++;
        #1;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL steady_ready got=%b exp=1", h_ready); else passes++;
        repeat (7) @(negedge clk);
        disp_pos = 11'd1;
        #1;
        checks++;
        if (h_ready !== 1'b0) $display("FAIL fetch1_ready got=%b exp=0", h_ready); else passes++;
        @(negedge clk);
        checks++;
        if (disp_char !== 8'h42) $display("FAIL fetch1_char got=%h exp=42", disp_char); else passes++;
        #1;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL after_fetch_ready got=%b exp=1", h_ready); else passes++;
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int bad = 0;
        logic [7:0] d;
        logic v;
        for (int i = 0; i < 32; i++) begin
            if (i % 8 == 0) disp_pos = 11'(10 + i / 8);
            h_valid = 1'b1; h_we = 1'b1;
            h_addr = 11'(200 + k); h_wdata = 8'(k + 1);
            #1;
            if (h_ready) k++;
            @(negedge clk);
        end
        h_valid = 1'b0; h_we = 1'b0;
        checks++;
        if (k !== 28) $display("FAIL b2b_accepted got=%0d exp=28", k); else passes++;
        for (int j = 0; j < 28; j++) begin
            host_read(11'(200 + j), d, v);
            if (v !== 1'b1 || d !== 8'(j + 1)) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL b2b_data bad_cells=%0d exp=0", bad); else passes++;
    endtask

    task automatic test_clear();
        int b = 0;
        int f = 0;
        int rdy = 0;
        int cyc = 0;
        int bad = 0;
        logic done = 1'b0;
        logic [7:0] d;
        logic v;
        clr_req = 1'b1;
        #1;
        checks++;
        if (h_ready !== 1'b0) $display("FAIL clr_req_ready got=%b exp=0", h_ready); else passes++;
        @(negedge clk);
        clr_req = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL clr_busy got=%b exp=1", busy); else passes++;
        while (cyc < 3000 && !done) begin
            if (cyc % 8 == 3) disp_pos = (disp_pos == 11'd13) ? 11'd14 : 11'd13;
            clr_req = (cyc == 500);
            #1;
            if (!busy) begin
                done = 1'b1;
            end else begin
                b++;
                if (cyc % 8 == 3) f++;
                if (h_ready) rdy++;
                @(negedge clk);
                cyc++;
            end
        end
        clr_req = 1'b0;
        checks++;
        if (!done) $display("FAIL clr_timeout busy still 1 after %0d cycles, required 0", cyc); else passes++;
        checks++;
        if (b !== 2000 + f) $display("FAIL clr_busy_len got=%0d exp=%0d", b, 2000 + f); else passes++;
        checks++;
        if (rdy !== 0) $display("FAIL clr_ready_seen got=%0d exp=0", rdy); else passes++;
        for (int j = 0; j < 2000; j++) begin
            host_read(11'(j), d, v);
            if (v !== 1'b1 || d !== 8'h20) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL clr_cells bad_cells=%0d exp=0", bad); else passes++;
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        logic v;
        host_write(11'd2000, 8'h55);
        host_read(11'd2000, d, v);
        checks++;
        if (v !== 1'b1) $display("FAIL oob_rvalid got=%b exp=1", v); else passes++;
        checks++;
        if (d !== 8'h00) $display("FAIL oob_rdata got=%h exp=00", d); else passes++;
        host_read(11'd1999, d, v);
        checks++;
        if (d !== 8'h20) $display("FAIL last_cell got=%h exp=20", d); else passes++;
        disp_pos = 11'd3;
        @(negedge clk);
        checks++;
        if (disp_char !== 8'h20) $display("FAIL disp3_char got=%h exp=20", disp_char); else passes++;
        disp_pos = 11'd2047;
        #1;
        checks++;
        if (h_ready !== 1'b1) $display("FAIL oob_fetch_ready got=%b exp=1", h_ready); else passes++;
        @(negedge clk);
        checks++;
        if (disp_char !== 8'h00) $display("FAIL oob_disp_char got=%h exp=00", disp_char); else passes++;
    endtask

`ifdef TEXT_BUF_CURSOR_EN
    task automatic sample_cursor(output logic [7:0] c);
        disp_pos = 11'd2047;
        @(negedge clk);
        disp_pos = 11'd3;
        @(negedge clk);
        c = disp_char;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_cursor();
        logic [7:0] exp_seq [0:4];
        logic [7:0] c;
        logic [7:0] d;
        logic v;
        exp_seq[0] = 8'h41; exp_seq[1] = 8'h41; exp_seq[2] = 8'hC1;
        exp_seq[3] = 8'hC1; exp_seq[4] = 8'h41;
        cursor_pos = 11'd3;
        host_write(11'd3, 8'h41);
        for (int t = 0; t < 5; t++) begin
            if (t != 0) pulse_frame();
            sample_cursor(c);
            checks++;
            if (c !== exp_seq[t]) $display("FAIL cursor_ticks%0d got=%h exp=%h", t, c, exp_seq[t]); else passes++;
            if (t == 2) begin
                host_read(11'd3, d, v);
                checks++;
                if (d !== 8'h41) $display("FAIL cursor_host_raw got=%h exp=41", d); else passes++;
            end
        end
        disp_pos = 11'd2047;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_clear();
        logic [7:0] d;
        logic v;
        host_write(11'd0, 8'h5A);
        host_write(11'd1500, 8'h77);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL midclr_busy got=%b exp=1", busy); else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL async_reset_busy got=%b exp=0", busy); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else passes++;
        host_read(11'd0, d, v);
        checks++;
        if (d !== 8'h20) $display("FAIL partial_clear_cell0 got=%h exp=20", d); else passes++;
        host_read(11'd1500, d, v);
        checks++;
        if (d !== 8'h77) $display("FAIL partial_clear_cell1500 got=%h exp=77", d); else passes++;
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_fetch();
        test_back_to_back();
        test_clear();
        test_out_of_range();
`ifdef TEXT_BUF_CURSOR_EN
        test_cursor();
`endif
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
